// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency valid/ready 64-bit data-memory responder for the LEGv8 datapath.
// Optional misaligned-access flagging under `DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, e_idx;
  logic [63:0] wdata_q, e_wdata, rdata_q;
  logic [63:0] mem_q [2**ADDR_BITS];
  logic wr_q, e_wr, err_q, e_err, req_err, accept, enter;
  logic unused;
  assign unused = ^{req_addr[63:ADDR_BITS+3], req_addr[2:0]};
  assign accept = state_q == IDLE && req_valid && (req_read || req_write);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = LATENCY == 1 ? RESP : WAIT;
        cnt_d = 4'(LATENCY - 1);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // With LATENCY==1 the RESP entry edge is the accept edge, so the live request is used.
  assign enter = state_d == RESP && state_q != RESP;
  assign e_idx = state_q == IDLE ? req_addr[ADDR_BITS+2:3] : idx_q;
  assign e_wdata = state_q == IDLE ? req_wdata : wdata_q;
  assign e_wr = state_q == IDLE ? req_write : wr_q;
  assign e_err = state_q == IDLE ? req_err : err_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (enter) rdata_q <= e_err ? '0 : mem_q[e_idx];
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= req_addr[ADDR_BITS+2:3];
      wdata_q <= req_wdata;
      wr_q <= req_write;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && enter && e_wr && !e_err) mem_q[e_idx] <= e_wdata;
  end
`ifdef DMEM_MISALIGN_CHK_EN
  logic rsp_err_q;
  assign req_err = |req_addr[2:0];
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) err_q <= req_err;
      if (enter) rsp_err_q <= e_err;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign req_err = 1'b0;
  assign err_q = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;
  logic clk = 0, reset = 0, req_valid = 0, req_read = 0, req_write = 0, rsp_ready = 1;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic rdy [3], vld [3], err [3], bsy [3];
  logic [63:0] rdat [3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_responder #(.ADDR_BITS(6), .LATENCY(2)) u2 (.clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(rdy[0]), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdat[0]),
    .rsp_err(err[0]), .busy(bsy[0]));
  dmem_responder #(.ADDR_BITS(6), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(rdy[1]), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdat[1]),
    .rsp_err(err[1]), .busy(bsy[1]));
  dmem_responder #(.ADDR_BITS(6), .LATENCY(15)) u15 (.clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(rdy[2]), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdat[2]),
    .rsp_err(err[2]), .busy(bsy[2]));
  typedef struct {
    logic rd, wr;
    logic [63:0] a, d, q;
    logic e, chk;
  } vec_t;
  vec_t tv [14];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic txn(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] q, output logic e, output int lat);
    @(negedge clk);
    req_valid = 1; req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_read = 0; req_write = 0;
    lat = 1;
    while (!vld[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = rdat[0];
    e = err[0];
    @(posedge clk);
  endtask
  initial begin
    logic [63:0] q, hold, old08;
    logic e;
    int lat, f1, f15;
    bit bad;
    tv[0]  = '{0, 1, 64'h10, 64'hDEAD_BEEF_0000_0001, 64'h0, 0, 0};
    tv[1]  = '{1, 0, 64'h10, 64'h0, 64'hDEAD_BEEF_0000_0001, 0, 1};
    tv[2]  = '{0, 1, 64'h000, 64'hAA, 64'h0, 0, 0};
    tv[3]  = '{1, 0, 64'h200, 64'h0, 64'hAA, 0, 1};
    tv[4]  = '{0, 1, 64'h18, 64'h11, 64'h0, 0, 0};
    tv[5]  = '{1, 1, 64'h18, 64'h77, 64'h11, 0, 1};
    tv[6]  = '{1, 0, 64'h18, 64'h0, 64'h77, 0, 1};
    tv[7]  = '{0, 1, 64'h08, 64'h1234, 64'h0, 0, 0};
    tv[8]  = '{1, 0, 64'h08, 64'h0, 64'h1234, 0, 1};
`ifdef DMEM_MISALIGN_CHK_EN
    tv[9]  = '{0, 1, 64'h0C, 64'h99, 64'h0, 1, 1};
    tv[10] = '{1, 0, 64'h08, 64'h0, 64'h1234, 0, 1};
    tv[11] = '{1, 0, 64'h04, 64'h0, 64'h0, 1, 1};
    old08 = 64'h1234;
`else
    tv[9]  = '{0, 1, 64'h0C, 64'h99, 64'h1234, 0, 1};
    tv[10] = '{1, 0, 64'h08, 64'h0, 64'h99, 0, 1};
    tv[11] = '{1, 0, 64'h04, 64'h0, 64'hAA, 0, 1};
    old08 = 64'h99;
`endif
    tv[12] = '{0, 1, 64'hFFFF_0000_0000_0010, 64'h5, 64'hDEAD_BEEF_0000_0001, 0, 1};
    tv[13] = '{1, 0, 64'h10, 64'h0, 64'h5, 0, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy[0], 1); chk("rst_valid", vld[0], 0); chk("rst_rdata", rdat[0], 0);
    chk("rst_err", err[0], 0); chk("rst_busy", bsy[0], 0);
    reset = 1;
    // LATENCY 1 / 15 timing on a word written beforehand in all three instances
    txn(0, 1, 64'h20, 64'hC0FFEE, q, e, lat);
    repeat (20) @(negedge clk);
    req_valid = 1; req_read = 1; req_addr = 64'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_read = 0;
    f1 = 0; f15 = 0; bad = 0;
    for (int k = 1; k <= 16; k++) begin
      if (f1 == 0 && vld[1]) f1 = k;
      if (f15 == 0 && vld[2]) f15 = k;
      if (k == 1) chk("l1_busy", bsy[1], 1);
      if (k <= 15 && (!bsy[2] || rdy[2])) bad = 1;
      if (k == 15) chk("l15_rdata", rdat[2], 64'hC0FFEE);
      @(negedge clk);
    end
    chk("l1_latency", 64'(f1), 1);
    chk("l15_latency", 64'(f15), 15);
    chk("l15_busy_throughout", 64'(bad), 0);
    for (int i = 0; i < 14; i++) begin
      txn(tv[i].rd, tv[i].wr, tv[i].a, tv[i].d, q, e, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 2);
      if (tv[i].chk) chk($sformatf("v%0d_rdata", i), q, tv[i].q);
      chk($sformatf("v%0d_err", i), e, tv[i].e);
    end
    // Back-pressure: response held while a competing request waits
    @(negedge clk);
    rsp_ready = 0;
    req_valid = 1; req_read = 1; req_addr = 64'h18;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!vld[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 64'(lat), 2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!vld[0] || rdat[0] !== 64'h77 || rdy[0]) bad = 1;
    end
    chk("bp_stable", 64'(bad), 0);
    chk("bp_rdata", rdat[0], 64'h77);
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_after_hs_valid", vld[0], 0);
    chk("bp_after_hs_ready", rdy[0], 1);
    @(negedge clk);
    chk("bp_reaccept_busy", bsy[0], 1);
    req_valid = 0; req_read = 0;
    lat = 0;
    while (!vld[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_rsp", rdat[0], 64'h77);
    repeat (20) @(negedge clk);
    // Request with neither read nor write is ignored
    req_valid = 1;
    @(negedge clk);
    chk("noop_busy", bsy[0], 0);
    chk("noop_ready", rdy[0], 1);
    req_valid = 0;
    // Reset during WAIT aborts the store
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 64'h08; req_wdata = 64'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_write = 0;
    chk("abort_wait_busy", bsy[0], 1);
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", rdy[0], 1); chk("abort_valid", vld[0], 0); chk("abort_rdata", rdat[0], 0);
    chk("abort_err", err[0], 0); chk("abort_busy", bsy[0], 0);
    reset = 1;
    txn(1, 0, 64'h08, 64'h0, q, e, lat);
    chk("abort_old_word", q, old08);
    chk("abort_load_latency", 64'(lat), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
